// File: rtl/sprite_ram_dma_pkg.sv
// sprite_ram_dma_pkg: shared AHB codes, sprite RAM constants and the DMA state/request types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_ram_dma_pkg;

    localparam int          SPRITE_NUM_MAX  = 64;
    localparam logic [1:0]  HTRANS_IDLE     = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0]  HSIZE_WORD      = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE   = 3'b000;
    localparam logic [3:0]  HPROT_DATA      = 4'b0011;
    localparam logic [31:0] SPRITE_RAM_BASE = 32'h4000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_D = 3'd4,
        ST_FIN  = 3'd5
    } dma_state_t;

    // Request parameters captured when a start is accepted; bases are word aligned.
    typedef struct packed {
        logic        fill_en;
        logic [31:0] fill_data;
        logic [31:0] src_base;
        logic [31:0] dst_base;
    } dma_req_t;

    // Byte address of word idx above base; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/sprite_ram_dma.sv
// sprite_ram_dma: AHB-Lite master that copies SPRITE_NUM words into the sprite RAM or fills it with a constant.
// Latency: start to done is 4*SPRITE_NUM+1 cycles (copy) or 2*SPRITE_NUM+1 cycles (fill) with zero wait states.
// Backpressure: every address and data phase holds while HREADY=0; only one transfer is ever outstanding.
module sprite_ram_dma
    import sprite_ram_dma_pkg::*;
#(
    parameter int SPRITE_NUM = SPRITE_NUM_MAX,
    parameter int CNT_BIT    = 7
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        start,
    input  logic        fill_en,
    input  logic [31:0] fill_data,
    input  logic [31:0] src_base,
    input  logic [31:0] dst_base,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    dma_state_t         state;
    dma_state_t         state_nxt;
    dma_req_t           req;
    logic [CNT_BIT-1:0] cnt;
    logic [31:0]        data_q;
    logic               accept;
    logic               cnt_inc;
    logic               data_cap;
    logic               err_set;
    logic               last;

    assign last   = (cnt == CNT_BIT'(SPRITE_NUM - 1));
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_DATA;

    // State register; reset drops straight back to IDLE so the bus sees HTRANS=IDLE at once.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, entry counter, read-data holding register and sticky error flag.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            req    <= '0;
            cnt    <= '0;
            data_q <= '0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                req.fill_en   <= fill_en;
                req.fill_data <= fill_data;
                req.src_base  <= src_base & 32'hFFFF_FFFC;
                req.dst_base  <= dst_base & 32'hFFFF_FFFC;
                cnt           <= '0;
                err           <= 1'b0;
            end
            if (cnt_inc) begin
                cnt <= cnt + CNT_BIT'(1);
            end
            if (data_cap) begin
                data_q <= HRDATA;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Next-state decode and bus drive: address phases issue NONSEQ, data phases keep HTRANS=IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cnt_inc   = 1'b0;
        data_cap  = 1'b0;
        err_set   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        HTRANS    = HTRANS_IDLE;
        HWRITE    = 1'b0;
        HADDR     = '0;
        HWDATA    = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = fill_en ? ST_WR_A : ST_RD_A;
                end
            end
            ST_RD_A: begin
                busy   = 1'b1;
                HTRANS = HTRANS_NONSEQ;
                HADDR  = word_addr(req.src_base, 32'(cnt));
                if (HREADY) begin
                    state_nxt = ST_RD_D;
                end
            end
            ST_RD_D: begin
                busy = 1'b1;
                if (HREADY) begin
                    if (HRESP) begin
                        err_set   = 1'b1;
                        state_nxt = ST_FIN;
                    end else begin
                        data_cap  = 1'b1;
                        state_nxt = ST_WR_A;
                    end
                end
            end
            ST_WR_A: begin
                busy   = 1'b1;
                HTRANS = HTRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = word_addr(req.dst_base, 32'(cnt));
                if (HREADY) begin
                    state_nxt = ST_WR_D;
                end
            end
            ST_WR_D: begin
                busy   = 1'b1;
                HWDATA = req.fill_en ? req.fill_data : data_q;
                if (HREADY) begin
                    if (HRESP) begin
                        err_set   = 1'b1;
                        state_nxt = ST_FIN;
                    end else if (last) begin
                        state_nxt = ST_FIN;
                    end else begin
                        cnt_inc   = 1'b1;
                        state_nxt = req.fill_en ? ST_WR_A : ST_RD_A;
                    end
                end
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
